// File: rtl/gpu_fb_pkg.sv
// gpu_fb_pkg: shared framebuffer geometry and write-queue state encoding
package gpu_fb_pkg;
    localparam int GPU_ADDR_W   = 18;
    localparam int GPU_DATA_W   = 16;
    localparam int GPU_FB_WORDS = 76800;
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DRAIN      = 2'd1,
        ST_CLEAR_WAIT = 2'd2,
        ST_CLEAR      = 2'd3
    } fb_state_t;
endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: single-clock FIFO with level, full and empty flags
module fb_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_push;
    logic         w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    // storage array, written at the tail
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
    // head/tail pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fb_write_queue.sv
// fb_write_queue: buffers pixel writes and framebuffer clears into video-off SRAM windows
module fb_write_queue #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = gpu_fb_pkg::GPU_ADDR_W,
    parameter int DATA_W      = gpu_fb_pkg::GPU_DATA_W,
    parameter int AFULL_LEVEL = 12,
    parameter int FB_WORDS    = gpu_fb_pkg::GPU_FB_WORDS
) (
    input  logic                   I_CLK,
    input  logic                   I_RST_N,
    input  logic                   I_VIDEO_ON,
    input  logic                   I_PIX_VALID,
    input  logic [ADDR_W-1:0]      I_PIX_ADDR,
    input  logic [DATA_W-1:0]      I_PIX_DATA,
    output logic                   O_PIX_READY,
    input  logic                   I_CLEAR_REQ,
    input  logic [DATA_W-1:0]      I_CLEAR_COLOR,
    output logic                   O_CLEAR_BUSY,
    output logic [ADDR_W-1:0]      O_GPU_ADDR,
    output logic [DATA_W-1:0]      O_GPU_DATA,
    output logic                   O_GPU_WRITE,
    output logic                   O_GPU_READ,
    output logic                   O_STALL,
    output logic [$clog2(DEPTH):0] O_LEVEL
);
    import gpu_fb_pkg::*;
    localparam int LW = $clog2(DEPTH) + 1;
    fb_state_t                  r_state;
    fb_state_t                  w_next;
    logic                       r_init;
    logic [ADDR_W-1:0]          r_cnt;
    logic [DATA_W-1:0]          r_color;
    logic [ADDR_W+DATA_W-1:0]   w_rd;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_clr_wr;
    logic                       w_clr_last;
    logic                       w_clr_acc;
    fb_sync_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
        .i_clk   (I_CLK),
        .i_rst_n (I_RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({I_PIX_ADDR, I_PIX_DATA}),
        .o_data  (w_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (O_LEVEL)
    );
    assign O_PIX_READY  = r_init && !w_full && r_state != ST_CLEAR;
    assign O_CLEAR_BUSY = r_state == ST_CLEAR_WAIT || r_state == ST_CLEAR;
    assign O_STALL      = O_LEVEL >= LW'(AFULL_LEVEL) || O_CLEAR_BUSY;
    assign O_GPU_READ   = 1'b0;
    assign w_push       = I_PIX_VALID && O_PIX_READY;
    assign w_pop        = !I_VIDEO_ON && !w_empty && r_state != ST_CLEAR;
    assign w_clr_wr     = !I_VIDEO_ON && r_state == ST_CLEAR;
    assign w_clr_last   = w_clr_wr && r_cnt == ADDR_W'(FB_WORDS - 1);
    assign w_clr_acc    = I_CLEAR_REQ && !O_CLEAR_BUSY;
    // next state: a clear waits behind queued pixels, then owns the port until done
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       w_next = w_clr_acc ? (w_empty ? ST_CLEAR : ST_CLEAR_WAIT) : (w_empty ? ST_IDLE : ST_DRAIN);
            ST_DRAIN:      w_next = w_clr_acc ? ST_CLEAR_WAIT : (w_empty ? ST_IDLE : ST_DRAIN);
            ST_CLEAR_WAIT: w_next = w_empty ? ST_CLEAR : ST_CLEAR_WAIT;
            ST_CLEAR:      w_next = w_clr_last ? ST_IDLE : ST_CLEAR;
            default:       w_next = ST_IDLE;
        endcase
    end
    // state, ready-after-reset flag, clear colour and clear address counter
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= ST_IDLE;
            r_init  <= 1'b0;
            r_cnt   <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            r_init  <= 1'b1;
            if (w_clr_acc) r_color <= I_CLEAR_COLOR;
            if (w_clr_wr)  r_cnt <= w_clr_last ? '0 : r_cnt + 1'b1;
        end
    end
    // registered SRAM write port; address/data hold when idle
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_GPU_ADDR  <= '0;
            O_GPU_DATA  <= '0;
            O_GPU_WRITE <= 1'b0;
        end else begin
            O_GPU_WRITE <= w_pop || w_clr_wr;
            if (w_pop) begin
                O_GPU_ADDR <= w_rd[ADDR_W+DATA_W-1:DATA_W];
                O_GPU_DATA <= w_rd[DATA_W-1:0];
            end else if (w_clr_wr) begin
                O_GPU_ADDR <= r_cnt;
                O_GPU_DATA <= r_color;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_queue.sv
// tb_fb_write_queue: scoreboard bench for the framebuffer write queue
module tb_fb_write_queue;
    localparam int FBW = 2048;
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid = 1'b1;
    logic        pv = 1'b0;
    logic [17:0] pa = '0;
    logic [15:0] pd = '0;
    logic        creq = 1'b0;
    logic [15:0] cc = '0;
    logic        o_ready, o_busy, o_wr, o_rd, o_stall;
    logic [17:0] o_addr;
    logic [15:0] o_data;
    logic [4:0]  o_level;
    int          checks = 0;
    int          errors = 0;
    int          last_addr = -1;
    bit          done;
    wr_t         exp[$];

    fb_write_queue #(.DEPTH(16), .ADDR_W(18), .DATA_W(16), .AFULL_LEVEL(12), .FB_WORDS(FBW)) dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_VIDEO_ON(vid),
        .I_PIX_VALID(pv), .I_PIX_ADDR(pa), .I_PIX_DATA(pd), .O_PIX_READY(o_ready),
        .I_CLEAR_REQ(creq), .I_CLEAR_COLOR(cc), .O_CLEAR_BUSY(o_busy),
        .O_GPU_ADDR(o_addr), .O_GPU_DATA(o_data), .O_GPU_WRITE(o_wr), .O_GPU_READ(o_rd),
        .O_STALL(o_stall), .O_LEVEL(o_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, want);
        end
    endtask

    task automatic push_clear_words(input logic [15:0] c);
        for (int i = 0; i < FBW; i++) exp.push_back('{a: 18'(i), d: c});
    endtask

    task automatic push_px(input logic [17:0] a, input logic [15:0] d);
        int n;
        n = 0;
        pv = 1'b1; pa = a; pd = d;
        while (!o_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready still %0b after %0d cycles, want 1", o_ready, n);
        end else exp.push_back('{a: a, d: d});
        @(negedge clk);
        pv = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        for (int n = 0; n < lim && exp.size() != 0; n++) @(negedge clk);
        chk("drain_done", 64'(exp.size()), 0);
    endtask

    // monitor: every write must be in a video-off cycle and match the scoreboard head
    initial begin
        logic v;
        wr_t  e;
        forever begin
            @(posedge clk);
            v = vid;
            #1;
            if (o_wr) begin
                chk("video_window", 64'(v), 0);
                if (exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, want no write", o_addr, o_data);
                end else begin
                    e = exp.pop_front();
                    chk("wr_addr", 64'(o_addr), 64'(e.a));
                    chk("wr_data", 64'(o_data), 64'(e.d));
                end
                last_addr = int'(o_addr);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c1;
        #1;
        chk("rst_write", 64'(o_wr), 0);
        chk("rst_addr", 64'(o_addr), 0);
        chk("rst_data", 64'(o_data), 0);
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_stall", 64'(o_stall), 0);
        chk("rst_level", 64'(o_level), 0);
        chk("rst_ready", 64'(o_ready), 0);
        chk("rst_read", 64'(o_rd), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single pixel latency: accepted at edge K, written after edge K+1
        vid = 1'b0;
        pv = 1'b1; pa = 18'h00010; pd = 16'hF800;
        chk("t1_ready", 64'(o_ready), 1);
        exp.push_back('{a: 18'h00010, d: 16'hF800});
        @(posedge clk); #1;
        chk("t1_no_early_write", 64'(o_wr), 0);
        @(negedge clk);
        pv = 1'b0;
        chk("t1_level_one", 64'(o_level), 1);
        @(posedge clk); #1;
        chk("t1_write", 64'(o_wr), 1);
        chk("t1_addr", 64'(o_addr), 64'h10);
        chk("t1_data", 64'(o_data), 64'hF800);
        @(negedge clk);
        chk("t1_level_zero", 64'(o_level), 0);

        // fill during video-on, then burst drain
        vid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_px(18'($urandom), 16'($urandom));
            chk("t2_level", 64'(o_level), 64'(i + 1));
            chk("t2_stall", 64'(o_stall), 64'(i + 1 >= 12));
        end
        chk("t2_full_ready", 64'(o_ready), 0);
        vid = 1'b0;
        repeat (15) @(negedge clk);
        chk("t2_burst_level1", 64'(o_level), 1);
        @(negedge clk);
        chk("t2_burst_level0", 64'(o_level), 0);
        wait_drain(10);

        // streaming under a video toggle every 3 cycles
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    repeat (3) @(negedge clk);
                    vid = ~vid;
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    push_px(18'($urandom), 16'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done = 1'b1;
            end
        join
        vid = 1'b0;
        wait_drain(100);

        // clear behind 5 queued pixels
        vid = 1'b1;
        for (int i = 0; i < 5; i++) push_px(18'($urandom), 16'($urandom));
        creq = 1'b1; cc = 16'h07E0;
        push_clear_words(16'h07E0);
        @(negedge clk);
        creq = 1'b0;
        chk("t4_busy", 64'(o_busy), 1);
        chk("t4_stall", 64'(o_stall), 1);
        vid = 1'b0;
        for (int n = 0; n < FBW + 200 && o_busy; n++) @(negedge clk);
        chk("t4_busy_drop", 64'(o_busy), 0);
        chk("t4_all_written", 64'(exp.size()), 0);
        chk("t4_last_addr", 64'(last_addr), 64'(FBW - 1));

        // second pulse ignored, pause mid-clear, held push accepted after the clear
        c1 = 16'($urandom);
        creq = 1'b1; cc = c1;
        push_clear_words(c1);
        @(negedge clk);
        creq = 1'b0;
        repeat (3) @(negedge clk);
        creq = 1'b1; cc = ~c1;
        @(negedge clk);
        creq = 1'b0;
        chk("t5_ready_in_clear", 64'(o_ready), 0);
        vid = 1'b1;
        repeat (10) @(negedge clk);
        vid = 1'b0;
        push_px(18'($urandom), 16'($urandom));
        wait_drain(20);
        chk("t5_busy_done", 64'(o_busy), 0);

        // reset in the middle of a clear
        last_addr = -1;
        creq = 1'b1; cc = 16'($urandom);
        push_clear_words(cc);
        @(negedge clk);
        creq = 1'b0;
        for (int n = 0; n < 3000 && last_addr != 1000; n++) @(negedge clk);
        chk("t6_reached_1000", 64'(last_addr), 1000);
        rst_n = 1'b0;
        #1;
        exp.delete();
        chk("t6_write", 64'(o_wr), 0);
        chk("t6_addr", 64'(o_addr), 0);
        chk("t6_data", 64'(o_data), 0);
        chk("t6_busy", 64'(o_busy), 0);
        chk("t6_stall", 64'(o_stall), 0);
        chk("t6_level", 64'(o_level), 0);
        chk("t6_ready", 64'(o_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_idle_busy", 64'(o_busy), 0);
        chk("t6_idle_level", 64'(o_level), 0);
        chk("final_queue", 64'(exp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
